median_window_sequencer: RTL



---
 rtl/median_pkg.sv | 20 ++
 rtl/median_line_buffer.sv | 31 +++
 rtl/median_window_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared types for the median window sequencer: pixel type, controller states
// and the per-column output tag that rides alongside the median core latency.
package median_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/median_line_buffer.sv
// Two row-deep line buffer: prev2 holds row y-2 and prev1 holds row y-1 at
// column x; a write shifts the column up by one row (read-before-write).
module median_line_buffer
  import median_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int XW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [XW-1:0] x,
  input  pixel_t        din,
  output pixel_t        prev2,
  output pixel_t        prev1
);

  pixel_t lb1 [IMG_W];
  pixel_t lb0 [IMG_W];

  assign prev2 = lb1[x];
  assign prev1 = lb0[x];

  // Contents are don't-care after reset; FILL rewrites every entry.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1[x] <= lb0[x];
      lb0[x] <= din;
    end
  end

endmodule

// File: rtl/median_window_sequencer.sv
// Streams a raster frame through one sequential median core and emits only the
// medians of complete 3x3 windows. Optional MEDIAN_SEQ_CYCLE_COUNT_EN builds the
// frame_cycles counter; otherwise frame_cycles is tied to 0.
module median_window_sequencer
  import median_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int MED_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  pixel_t      in_pixel,
  input  logic        in_valid,
  output logic        in_ready,
  output pixel_t      col_top,
  output pixel_t      col_mid,
  output pixel_t      col_bot,
  output logic        col_valid,
  input  pixel_t      med_in,
  output pixel_t      out_pixel,
  output logic        out_valid,
  output logic        out_last,
  output logic        frame_done,
  output logic        busy,
  output logic [31:0] frame_cycles,
  output seq_state_t  dbg_state
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  seq_state_t    state, state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          accept, row_end, frame_end;
  pixel_t        lb_top, lb_mid;
  tag_t          col_tag;
  tag_t          tags [MED_LAT+1];

  // Handshake: a pixel transfers on a cycle where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  assign accept    = in_valid && in_ready;
  assign row_end   = (x == XW'(IMG_W - 1));
  assign frame_end = row_end && (y == YW'(IMG_H - 1));
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (accept && row_end && (y == YW'(1))) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (accept && frame_end) state_nxt = DRAIN;
      end
      DRAIN: if (out_last) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
      end else if (accept) begin
        if (row_end) begin
          x <= '0;
          y <= frame_end ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  median_line_buffer #(.IMG_W(IMG_W), .XW(XW)) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .x     (x),
    .din   (in_pixel),
    .prev2 (lb_top),
    .prev1 (lb_mid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_top   <= '0;
      col_mid   <= '0;
      col_bot   <= '0;
      col_valid <= 1'b0;
      col_tag   <= '0;
    end else begin
      col_valid <= accept && (state == RUN);
      if (accept && state == RUN) begin
        col_top       <= lb_top;
        col_mid       <= lb_mid;
        col_bot       <= in_pixel;
        // Columns 0 and 1 only prime the core's window.
        col_tag.valid <= (x >= XW'(2));
        col_tag.last  <= frame_end;
      end
    end
  end

  // Free-running tag line matching the core latency; tags[MED_LAT-1] marks the
  // cycle in which med_in carries a complete-window median.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MED_LAT; i++) tags[i] <= '0;
      out_pixel <= '0;
    end else begin
      tags[0] <= col_valid ? col_tag : '0;
      for (int i = 1; i <= MED_LAT; i++) tags[i] <= tags[i-1];
      if (tags[MED_LAT-1].valid) out_pixel <= med_in;
    end
  end

  assign out_valid = tags[MED_LAT].valid;
  assign out_last  = tags[MED_LAT].valid && tags[MED_LAT].last;

`ifdef MEDIAN_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;

  // Loads 1 so the value seen during DONE already includes that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && start) begin
      cycle_cnt <= 32'd1;
    end else if (state == FILL || state == RUN || state == DRAIN) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign frame_cycles = cycle_cnt;
`else
  assign frame_cycles = '0;
`endif

endmodule
